// File: rtl/axi_ram_reader.sv
// AXI4 read-only slave in front of a single-port synchronous RAM (1-cycle read latency).
// Bursts are streamed through a 2-entry skid FIFO so that one beat per cycle is sustained.
module axi_ram_reader #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned BATCH_WIDTH = 4,
    parameter int unsigned BYTE_WIDTH  = 8,
    parameter int unsigned ID_WIDTH    = 4
) (
    input  logic                                      clk_i,
    input  logic                                      rst_n_i,
    input  logic [ID_WIDTH-1:0]                       ar_id_i,
    input  logic [ADDR_WIDTH+$clog2(BATCH_WIDTH)-1:0] ar_addr_i,
    input  logic [7:0]                                ar_len_i,
    input  logic [2:0]                                ar_size_i,
    input  logic [1:0]                                ar_burst_i,
    input  logic                                      ar_valid_i,
    output logic                                      ar_ready_o,
    output logic [ID_WIDTH-1:0]                       r_id_o,
    output logic [BATCH_WIDTH*BYTE_WIDTH-1:0]         r_data_o,
    output logic [1:0]                                r_resp_o,
    output logic                                      r_last_o,
    output logic                                      r_valid_o,
    input  logic                                      r_ready_i,
    output logic [ADDR_WIDTH-1:0]                     ram_addr_o,
    input  logic [BATCH_WIDTH*BYTE_WIDTH-1:0]         ram_rdata_i
);
    localparam int unsigned DATA_WIDTH = BATCH_WIDTH * BYTE_WIDTH;
    localparam int unsigned OFF_W      = $clog2(BATCH_WIDTH);
    localparam int unsigned CNT_W      = 9;

    typedef enum logic {IDLE, BURST} state_e;

    state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [CNT_W-1:0]        left_q;
    logic                    fixed_q, err_q;
    logic                    infl_q, infl_last_q, infl_err_q;
    logic [DATA_WIDTH-1:0]   fifo_data_q [2];
    logic [1:0]              fifo_resp_q [2];
    logic                    fifo_last_q [2];
    logic                    wr_ptr_q, rd_ptr_q;
    logic [1:0]              cnt_q;
    logic                    ar_hs_c, pop_c, issue_c;
    logic [2:0]              slots_c;
    logic                    unused_ok_c;

    assign unused_ok_c = ^{ar_size_i, ar_addr_i[OFF_W-1:0]};

    // FIFO head drives the R channel directly, so it holds steady under backpressure.
    assign r_valid_o  = (cnt_q != 2'd0);
    assign r_data_o   = fifo_data_q[rd_ptr_q];
    assign r_resp_o   = fifo_resp_q[rd_ptr_q];
    assign r_last_o   = fifo_last_q[rd_ptr_q] & r_valid_o;
    assign r_id_o     = id_q;
    assign ram_addr_o = addr_q;
    assign pop_c      = r_valid_o & r_ready_i;
    assign ar_hs_c    = ar_valid_i & ar_ready_o;
    assign slots_c    = 3'(cnt_q) + 3'(infl_q) - 3'(pop_c);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ar_valid_i) state_d = BURST;
            BURST:   if (pop_c && r_last_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ar_ready_o = 1'b0;
        issue_c    = 1'b0;
        case (state_q)
            IDLE:    ar_ready_o = 1'b1;
            BURST:   issue_c = (left_q != CNT_W'(0)) && (slots_c < 3'd2);
            default: ar_ready_o = 1'b0;
        endcase
    end

    // Burst context and issue side: the RAM samples addr_q on the edge where issue_c is high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            id_q        <= '0;
            addr_q      <= '0;
            left_q      <= '0;
            fixed_q     <= 1'b0;
            err_q       <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            infl_err_q  <= 1'b0;
        end else begin
            infl_q      <= issue_c;
            infl_last_q <= (left_q == CNT_W'(1));
            infl_err_q  <= err_q;
            if (ar_hs_c) begin
                id_q    <= ar_id_i;
                addr_q  <= ar_addr_i[ADDR_WIDTH+OFF_W-1:OFF_W];
                left_q  <= CNT_W'(ar_len_i) + CNT_W'(1);
                fixed_q <= (ar_burst_i == 2'b00);
                err_q   <= ar_burst_i[1];
            end else if (issue_c) begin
                left_q <= left_q - CNT_W'(1);
                if (!fixed_q && !err_q) addr_q <= addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    // Capture side: error beats ride the same pipeline but carry zero data and SLVERR.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_resp_q[i] <= 2'b00;
                fifo_last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (infl_q) begin
                fifo_data_q[wr_ptr_q] <= infl_err_q ? '0 : ram_rdata_i;
                fifo_resp_q[wr_ptr_q] <= infl_err_q ? 2'b10 : 2'b00;
                fifo_last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop_c) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + 2'(infl_q) - 2'(pop_c);
        end
    end
endmodule

// File: tb/tb_axi_ram_reader.sv
// Scoreboard bench for axi_ram_reader: bursts push expected beats, a monitor pops on each R handshake.
module tb_axi_ram_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ar_id = '0;
    logic [17:0] ar_addr = '0;
    logic [7:0]  ar_len = '0;
    logic [2:0]  ar_size = 3'd2;
    logic [1:0]  ar_burst = '0;
    logic        ar_valid = 1'b0;
    logic        ar_ready;
    logic [3:0]  r_id;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last, r_valid;
    logic        r_ready = 1'b1;
    logic [15:0] ram_addr;
    logic [31:0] ram_rdata = '0;

    axi_ram_reader dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_size_i(ar_size),
        .ar_burst_i(ar_burst), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
        .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last),
        .r_valid_o(r_valid), .r_ready_i(r_ready),
        .ram_addr_o(ram_addr), .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:65535];
    always @(posedge clk) ram_rdata <= mem[ram_addr];

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    passes = 0;
    int    pops = 0;
    int    ready_mode = 0;
    int    pat_idx = 0;
    int    cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Ready pattern: 0 = held high, 1 = random, 2 = 1,0,0,1,0,1 repeating.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: r_ready = 1'b1;
            1: r_ready = 1'($urandom_range(0, 1));
            default: begin
                case (pat_idx % 6)
                    0, 3, 5: r_ready = 1'b1;
                    default: r_ready = 1'b0;
                endcase
                pat_idx++;
            end
        endcase
    end

    // Monitor: pops the scoreboard on each handshake, checks stability while stalled.
    beat_t prev_b;
    logic  prev_stall = 1'b0;
    always @(negedge clk) begin
        beat_t cur, e;
        cur = '{id: r_id, data: r_data, resp: r_resp, last: r_last};
        if (rst_n && prev_stall && r_valid)
            chk("stall_stable", 64'(cur), 64'(prev_b));
        if (rst_n && r_valid && r_ready) begin
            pops++;
            if (exp_q.size() == 0) chk("unexpected_beat", 64'(cur), 64'h0);
            else begin
                e = exp_q.pop_front();
                chk("beat", 64'(cur), 64'(e));
            end
        end
        prev_stall = rst_n && r_valid && !r_ready;
        prev_b     = cur;
    end

    // Reference: beat n of a burst reads word base+n (INCR, mod 2^16), base (FIXED), or errors.
    task automatic send_ar(input logic [3:0] id, input logic [15:0] word, input logic [7:0] len,
                           input logic [1:0] burst, output int hs_cyc);
        int ok = 0;
        for (int i = 0; i <= int'(len); i++) begin
            beat_t b;
            logic [15:0] wa;
            wa = (burst == 2'b00) ? word : 16'(int'(word) + i);
            b.id   = id;
            b.data = burst[1] ? 32'h0 : mem[wa];
            b.resp = burst[1] ? 2'b10 : 2'b00;
            b.last = (i == int'(len));
            exp_q.push_back(b);
        end
        @(negedge clk);
        ar_id = id; ar_addr = {word, 2'($urandom_range(0, 3))}; ar_len = len;
        ar_burst = burst; ar_size = 3'($urandom_range(0, 7)); ar_valid = 1'b1;
        for (int t = 0; t < 1000 && !ok; t++) begin
            if (ar_ready) ok = 1;
            @(posedge clk);
        end
        hs_cyc = cyc;
        #1 ar_valid = 1'b0;
        if (!ok) chk("ar_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        int ok = 0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && ar_ready) ok = 1;
        end
        if (!ok) chk("burst_done_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int hs;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        mem[4] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk("rst_ar_ready", 64'(ar_ready), 64'd1);
        chk("rst_r_valid", 64'(r_valid), 64'd0);
        chk("rst_r_outs", 64'({r_id, r_data, r_resp, r_last}), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single beat with latency check: valid is first seen after edge k+2.
        send_ar(4'd3, 16'h0004, 8'd0, 2'b01, hs);
        @(negedge clk);
        @(negedge clk);
        chk("lat_k1_not_valid", 64'(r_valid), 64'd0);
        @(negedge clk);
        chk("lat_k2_valid", 64'(r_valid), 64'd1);
        wait_done();

        // INCR streaming: no bubbles after the first beat.
        send_ar(4'd1, 16'h0000, 8'd7, 2'b01, hs);
        begin
            int seen = 0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                if (r_valid) seen = 1;
            end
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                chk("stream_no_bubble", 64'(r_valid), 64'd1);
            end
        end
        wait_done();

        // Backpressure pattern.
        ready_mode = 2; pat_idx = 0;
        send_ar(4'd7, 16'h0123, 8'd3, 2'b01, hs);
        wait_done();
        ready_mode = 0;

        // Address wrap and FIXED.
        send_ar(4'd2, 16'hFFFE, 8'd3, 2'b01, hs);
        wait_done();
        send_ar(4'd5, 16'h0005, 8'd2, 2'b00, hs);
        wait_done();

        // Error bursts (WRAP and reserved), then a normal burst is still accepted.
        send_ar(4'd9, 16'h0040, 8'd1, 2'b10, hs);
        wait_done();
        send_ar(4'd10, 16'h0041, 8'd2, 2'b11, hs);
        wait_done();
        send_ar(4'd4, 16'h0042, 8'd1, 2'b01, hs);
        wait_done();

        // Maximum length.
        send_ar(4'd6, 16'hFF80, 8'd255, 2'b01, hs);
        wait_done();

        // Randomized bursts under random backpressure.
        ready_mode = 1;
        for (int n = 0; n < 16; n++) begin
            logic [1:0] bt;
            bt = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            send_ar(4'($urandom), 16'($urandom), 8'($urandom_range(0, 20)), bt, hs);
            wait_done();
        end
        ready_mode = 0;

        // Reset during beat 3 of an 8-beat burst.
        begin
            int base, ok;
            base = pops; ok = 0;
            send_ar(4'd8, 16'h2000, 8'd7, 2'b01, hs);
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk);
                if (pops >= base + 2) ok = 1;
            end
            if (!ok) chk("reset_setup_timeout", 64'd0, 64'd1);
            @(posedge clk);
            #3 rst_n = 1'b0;
            #1;
            chk("midrst_r_valid", 64'(r_valid), 64'd0);
            chk("midrst_ar_ready", 64'(ar_ready), 64'd1);
            exp_q.delete();
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (4) @(negedge clk);
            chk("post_rst_idle", 64'({r_valid, ar_ready}), 64'b01);
        end
        send_ar(4'd11, 16'h0004, 8'd3, 2'b01, hs);
        wait_done();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
